// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the parametrised data memory with hardware stack.
package data_memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } mem_state_t;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_memory_clear_engine.sv
// Post-reset sweep that zeroes every word of the array, one word per cycle,
// before the memory accepts any request.
module data_memory_clear_engine
  import data_memory_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = addr_width(DEPTH)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  mem_state_t    state_q;
  mem_state_t    state_d;
  logic [AW-1:0] clr_addr_q;
  logic [AW-1:0] clr_addr_d;

  // State and sweep address registers; reset restarts the sweep from word 0.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next-state: leave CLEAR right after the last word has been written.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
      IDLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = clr_addr_q;

endmodule

// File: rtl/data_memory_stack.sv
// Data memory with two combinational read ports, a store port and a hardware
// stack growing downward from the top of the same array.
module data_memory_stack
  import data_memory_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 256,
  parameter int STACK_DEPTH    = 16,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = addr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_enable,
  input  logic [AW-1:0]    address,
  output logic [WIDTH-1:0] data_out,
  input  logic [AW-1:0]    address_b,
  output logic [WIDTH-1:0] data_out_b,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] stack_top,
  output logic [AW:0]      sp,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             conflict,
  output logic             busy
);

  localparam logic [AW:0] SP_EMPTY = (AW + 1)'(DEPTH);
  localparam logic [AW:0] SP_FULL  = (AW + 1)'(DEPTH - STACK_DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      sp_q;
  logic [AW:0]      sp_d;
  logic [AW:0]      sp_dec_s;
  logic             overflow_q;
  logic             overflow_d;
  logic             underflow_q;
  logic             underflow_d;
  logic             conflict_q;
  logic             conflict_d;
  logic             empty_s;
  logic             full_s;
  logic             clr_busy_s;
  logic             clr_we_s;
  logic [AW-1:0]    clr_addr_s;
  logic             mem_we_s;
  logic [AW-1:0]    mem_waddr_s;
  logic [WIDTH-1:0] mem_wdata_s;

  data_memory_clear_engine #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clock_i    (clock),
    .reset_i    (reset),
    .busy_o     (clr_busy_s),
    .clr_we_o   (clr_we_s),
    .clr_addr_o (clr_addr_s)
  );

  assign empty_s  = (sp_q == SP_EMPTY);
  assign full_s   = (sp_q == SP_FULL);
  assign sp_dec_s = sp_q - (AW + 1)'(1);

  // Request arbitration onto the single array write port; push outranks store.
  always_comb begin
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    conflict_d  = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = data_in;
    if (clr_busy_s) begin
      mem_we_s    = clr_we_s;
      mem_waddr_s = clr_addr_s;
      mem_wdata_s = '0;
    end else if (push) begin
      conflict_d = write_enable;
      if (pop && !empty_s) begin
        mem_we_s    = 1'b1;
        mem_waddr_s = sp_q[AW-1:0];
      end else if (!full_s) begin
        sp_d        = sp_dec_s;
        mem_we_s    = 1'b1;
        mem_waddr_s = sp_dec_s[AW-1:0];
      end else begin
        overflow_d = 1'b1;
      end
    end else begin
      if (write_enable) begin
        mem_we_s    = 1'b1;
        mem_waddr_s = address;
      end else begin
        mem_we_s = 1'b0;
      end
      if (pop) begin
        if (!empty_s) begin
          sp_d = sp_q + (AW + 1)'(1);
        end else begin
          underflow_d = 1'b1;
        end
      end else begin
        sp_d = sp_q;
      end
    end
  end

  // Stack pointer and sticky/pulse flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q        <= SP_EMPTY;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      conflict_q  <= conflict_d;
    end
  end

  // Array storage: contents survive reset and are only zeroed by the sweep.
  always_ff @(posedge clock) begin
    if (mem_we_s && !reset) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign data_out   = mem_q[address];
  assign data_out_b = mem_q[address_b];
  assign stack_top  = mem_q[sp_q[AW-1:0]];
  assign sp         = sp_q;
  assign empty      = empty_s;
  assign full       = full_s;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign conflict   = conflict_q;
  assign busy       = clr_busy_s;

endmodule

// File: tb/tb_data_memory_stack.sv
// Scoreboard bench for data_memory_stack: the driver queues expected values,
// a negedge monitor pops and compares them against the live outputs.
module tb_data_memory_stack;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       write_enable;
  logic [7:0] address;
  logic [7:0] data_out;
  logic [7:0] address_b;
  logic [7:0] data_out_b;
  logic       push;
  logic       pop;
  logic [7:0] stack_top;
  logic [8:0] sp;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;
  logic       conflict;
  logic       busy;

  localparam int S_DOUT = 0, S_DOUTB = 1, S_TOP = 2, S_SP = 3, S_EMPTY = 4,
                 S_FULL = 5, S_OVF = 6, S_UNF = 7, S_CONF = 8, S_BUSY = 9;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   mon_act;
  int   checks   = 0;
  int   failures = 0;

  data_memory_stack dut (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .write_enable (write_enable),
    .address      (address),
    .data_out     (data_out),
    .address_b    (address_b),
    .data_out_b   (data_out_b),
    .push         (push),
    .pop          (pop),
    .stack_top    (stack_top),
    .sp           (sp),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .underflow    (underflow),
    .conflict     (conflict),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      case (mon_e.sel)
        S_DOUT:  mon_act = int'(data_out);
        S_DOUTB: mon_act = int'(data_out_b);
        S_TOP:   mon_act = int'(stack_top);
        S_SP:    mon_act = int'(sp);
        S_EMPTY: mon_act = int'(empty);
        S_FULL:  mon_act = int'(full);
        S_OVF:   mon_act = int'(overflow);
        S_UNF:   mon_act = int'(underflow);
        S_CONF:  mon_act = int'(conflict);
        S_BUSY:  mon_act = int'(busy);
        default: mon_act = -1;
      endcase
      checks++;
      if (mon_act != mon_e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%0h required 0x%0h at %0t", mon_e.name, mon_act, mon_e.exp, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_push(input string name, input int sel, input int val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = val;
    sb_q.push_back(e);
  endtask

  task automatic idle_in();
    write_enable = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
  endtask

  initial begin
    reset = 1'b1; data_in = 8'h00; address = 8'h00; address_b = 8'h00;
    idle_in();
    step(); step();
    reset = 1'b0;
    exp_push("rst_sp", S_SP, 256);
    exp_push("rst_empty", S_EMPTY, 1);
    exp_push("rst_full", S_FULL, 0);
    exp_push("rst_ovf", S_OVF, 0);
    exp_push("rst_unf", S_UNF, 0);
    exp_push("rst_conf", S_CONF, 0);
    // first sweep interrupted by reset after 100 cycles
    for (int i = 0; i < 100; i++) begin
      exp_push("busy_first", S_BUSY, 1);
      step();
    end
    reset = 1'b1;
    exp_push("busy_at_rerst", S_BUSY, 1);
    step();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      exp_push("busy_restart", S_BUSY, 1);
      step();
    end
    exp_push("busy_done", S_BUSY, 0);

    // preload, then reset and expect a full 256-cycle sweep to zero them
    write_enable = 1'b1; address = 8'd17; data_in = 8'hAA; step();
    address = 8'd255; data_in = 8'h55; step();
    write_enable = 1'b0; address = 8'd17; address_b = 8'd255;
    exp_push("preload_17", S_DOUT, 8'hAA);
    exp_push("preload_255", S_DOUTB, 8'h55);
    step();
    reset = 1'b1; step();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i >= 10 && i <= 12) begin
        write_enable = 1'b1; push = 1'b1; pop = 1'b1; address = 8'd5; data_in = 8'h77;
      end else begin
        idle_in();
      end
      if (i == 13) begin
        exp_push("busy_no_conf", S_CONF, 0);
        exp_push("busy_no_sp", S_SP, 256);
        exp_push("busy_no_ovf", S_OVF, 0);
        exp_push("busy_no_unf", S_UNF, 0);
      end
      exp_push("busy_clear2", S_BUSY, 1);
      step();
    end
    exp_push("busy_done2", S_BUSY, 0);
    address = 8'd17; address_b = 8'd255;
    exp_push("cleared_17", S_DOUT, 0);
    exp_push("cleared_255", S_DOUTB, 0);
    step();
    address = 8'd5;
    exp_push("busy_store_ignored", S_DOUT, 0);
    step();

    // store then read on port B, neighbour on port A
    write_enable = 1'b1; address = 8'd5; data_in = 8'h3C; step();
    write_enable = 1'b0; address_b = 8'd5; address = 8'd6;
    exp_push("store_b5", S_DOUTB, 8'h3C);
    exp_push("store_a6", S_DOUT, 0);
    step();

    // push/pop ordering
    push = 1'b1; data_in = 8'h11; step();
    data_in = 8'h22; step();
    data_in = 8'h33; step();
    push = 1'b0;
    exp_push("push3_sp", S_SP, 253);
    exp_push("push3_top", S_TOP, 8'h33);
    pop = 1'b1;
    exp_push("pop_1", S_TOP, 8'h33); step();
    exp_push("pop_2", S_TOP, 8'h22); step();
    exp_push("pop_3", S_TOP, 8'h11); step();
    pop = 1'b0;
    exp_push("pop3_sp", S_SP, 256);
    exp_push("pop3_empty", S_EMPTY, 1);

    // push+pop with non-empty stack replaces the top
    push = 1'b1; data_in = 8'h33; step();
    pop = 1'b1; data_in = 8'h44; step();
    idle_in();
    exp_push("replace_top", S_TOP, 8'h44);
    exp_push("replace_sp", S_SP, 255);
    pop = 1'b1; step(); pop = 1'b0;

    // push+pop on empty stack acts as plain push
    push = 1'b1; pop = 1'b1; data_in = 8'h12; step();
    idle_in();
    exp_push("pp_empty_sp", S_SP, 255);
    exp_push("pp_empty_top", S_TOP, 8'h12);
    exp_push("pp_empty_unf", S_UNF, 0);
    pop = 1'b1; step(); pop = 1'b0;

    // store dropped by push
    write_enable = 1'b1; push = 1'b1; address = 8'd2; data_in = 8'h5A; step();
    idle_in();
    exp_push("conf_addr2", S_DOUT, 0);
    exp_push("conf_pulse", S_CONF, 1);
    exp_push("conf_top", S_TOP, 8'h5A);
    exp_push("conf_sp", S_SP, 255);
    step();
    exp_push("conf_clear", S_CONF, 0);
    pop = 1'b1; step(); pop = 1'b0;

    // store and pop on the same word: store wins
    push = 1'b1; data_in = 8'h21; step();
    push = 1'b0; pop = 1'b1; write_enable = 1'b1; address = 8'd255; data_in = 8'h66; step();
    idle_in();
    exp_push("alias_store", S_DOUT, 8'h66);
    exp_push("alias_sp", S_SP, 256);

    // fill to full, then overflow
    push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'(8'h80 + i);
      step();
    end
    push = 1'b0;
    exp_push("full_flag", S_FULL, 1);
    exp_push("full_sp", S_SP, 240);
    exp_push("full_ovf0", S_OVF, 0);
    exp_push("full_top", S_TOP, 8'h8F);
    push = 1'b1; data_in = 8'h99; step();
    push = 1'b0; address = 8'd239;
    exp_push("ovf_core239", S_DOUT, 0);
    exp_push("ovf_sp", S_SP, 240);
    exp_push("ovf_flag", S_OVF, 1);
    exp_push("ovf_top", S_TOP, 8'h8F);
    exp_push("ovf_full", S_FULL, 1);

    // drain, then underflow
    pop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_push("drain_top", S_TOP, 8'h8F - i);
      step();
    end
    pop = 1'b0;
    exp_push("drain_empty", S_EMPTY, 1);
    exp_push("drain_unf0", S_UNF, 0);
    exp_push("drain_full0", S_FULL, 0);
    pop = 1'b1; step(); pop = 1'b0;
    exp_push("unf_flag", S_UNF, 1);
    exp_push("unf_sp", S_SP, 256);
    exp_push("ovf_sticky", S_OVF, 1);
    step();
    @(negedge clock);
    #1;
    checks++;
    if (sp !== 9'd256) begin
      failures++;
      $display("FAIL final_sp: got 0x%0h required 0x100", sp);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL final_busy: got %0b required 0", busy);
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL final_ovf: got %0b required 1", overflow);
    end
    checks++;
    if (underflow !== 1'b1) begin
      failures++;
      $display("FAIL final_unf: got %0b required 1", underflow);
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL final_empty: got %0b required 1", empty);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
